// File: rtl/soft_ides_n.sv
// soft_ides_n: soft serial-to-parallel deserialiser, LANES lanes sharing one word boundary, with bitslip.
// Defining SOFT_IDES_AUTO_ALIGN_EN adds a lane-0 training-word auto-align FSM driving locked_o.
module soft_ides_n #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LANES   = 1,
    parameter logic [15:0] TRAIN   = 16'h00FF,
    parameter int unsigned MATCH_N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       data_i,
    input  logic                   calib,
    output logic [LANES*WIDTH-1:0] q_o,
    output logic                   valid_o,
    output logic                   pclk_o,
    output logic                   locked_o
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

    logic [CW-1:0]                cnt;
    logic [LANES-1:0][WIDTH-1:0]  sr;
    logic [LANES*WIDTH-1:0]       word;
    logic                         slip;
    logic                         capture;
    logic                         int_slip;
    logic                         unused_bits;

    // Word completes with the bit being sampled now, so capture needs no extra pipeline stage.
    always_comb begin
        word = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            word[l*WIDTH +: WIDTH] = {data_i[l], sr[l][WIDTH-1:1]};
        end
    end

    assign slip    = calib | int_slip;
    assign capture = !slip && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sr      <= '0;
            q_o     <= '0;
            valid_o <= 1'b0;
            pclk_o  <= 1'b0;
        end else begin
            valid_o <= capture;
            pclk_o  <= (cnt < HALF);
            if (!slip) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    sr[l] <= {data_i[l], sr[l][WIDTH-1:1]};
                end
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            if (capture) begin
                q_o <= word;
            end
        end
    end

    assign unused_bits = ^{sr, TRAIN, MATCH_N};

`ifdef SOFT_IDES_AUTO_ALIGN_EN
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t     state, state_nx;
    logic [3:0] mcnt, mcnt_nx;
    logic       slip_nx;
    logic       match;

    assign match = (word[WIDTH-1:0] == TRAIN[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            mcnt     <= '0;
            int_slip <= 1'b0;
        end else begin
            state    <= state_nx;
            mcnt     <= mcnt_nx;
            int_slip <= slip_nx;
        end
    end

    // A rejected word requests one slip on the following cycle, which lands at cnt==0.
    always_comb begin
        state_nx = state;
        mcnt_nx  = mcnt;
        slip_nx  = 1'b0;
        case (state)
            SEARCH: begin
                if (capture) begin
                    if (match) begin
                        mcnt_nx  = 4'd1;
                        state_nx = (4'd1 == 4'(MATCH_N)) ? LOCKED : CHECK;
                    end else begin
                        slip_nx = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (capture) begin
                    if (match) begin
                        mcnt_nx = mcnt + 4'd1;
                        if (mcnt + 4'd1 == 4'(MATCH_N)) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        state_nx = SEARCH;
                        mcnt_nx  = '0;
                        slip_nx  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (calib) begin
                    state_nx = SEARCH;
                    mcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = SEARCH;
                mcnt_nx  = '0;
            end
        endcase
    end

    assign locked_o = (state == LOCKED);
`else
    assign int_slip = 1'b0;
    assign locked_o = 1'b0;
`endif

endmodule
